// File: rtl/arb_req_issuer.sv
// Requester-side lane bank for the weighted round-robin arbiter: counts pending tokens,
// drives req, flags grant protocol errors. Optional starvation detect: ARB_REQ_STARVE_DETECT_EN.
module arb_req_issuer #(
    parameter int NUM_REQ      = 10,
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] push_valid_i,
    output logic [NUM_REQ-1:0] push_ready_o,
    output logic [NUM_REQ-1:0] req_o,
    input  logic [NUM_REQ-1:0] gnt_i,
    output logic               gnt_err_o,
    output logic [NUM_REQ-1:0] starve_o
);

    localparam logic [CNT_W-1:0]   PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   PEND_ONE = CNT_W'(1);
    localparam logic [NUM_REQ-1:0] GNT_ONE  = NUM_REQ'(1);

    logic [CNT_W-1:0]   pend_q [NUM_REQ];
    logic [CNT_W-1:0]   pend_d [NUM_REQ];
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] consume;
    logic               gnt_err_q;
    logic               gnt_err_d;

    // Outputs depend on registered state only; no path from gnt_i/push_valid_i.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_o[i]        = (pend_q[i] != '0);
            push_ready_o[i] = (pend_q[i] != PEND_MAX);
        end
    end

    assign accept  = push_valid_i & push_ready_o;
    assign consume = gnt_i & req_o;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_d[i] = pend_q[i];
            if (accept[i] && !consume[i]) begin
                pend_d[i] = pend_q[i] + PEND_ONE;
            end else if (consume[i] && !accept[i]) begin
                pend_d[i] = pend_q[i] - PEND_ONE;
            end
        end
    end

    // Grant to an idle lane, or more than one grant bit set.
    assign gnt_err_d = (|(gnt_i & ~req_o)) | (|(gnt_i & (gnt_i - GNT_ONE)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_q[i] <= '0;
            end
            gnt_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_q[i] <= pend_d[i];
            end
            gnt_err_q <= gnt_err_d;
        end
    end

    assign gnt_err_o = gnt_err_q;

`ifdef ARB_REQ_STARVE_DETECT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(STARVE_LIMIT);

    logic [15:0]        wait_q [NUM_REQ];
    logic [15:0]        wait_d [NUM_REQ];
    logic [NUM_REQ-1:0] starve_q;
    logic [NUM_REQ-1:0] starve_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (!req_o[i] || gnt_i[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_LIMIT) begin
                wait_d[i] = wait_q[i] + 16'd1;
            end
            starve_d[i] = (wait_d[i] == WAIT_LIMIT);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
            starve_q <= starve_d;
        end
    end

    assign starve_o = starve_q;
`else
    assign starve_o = '0;
`endif

endmodule

// File: tb/tb_arb_req_issuer.sv
// Bench for arb_req_issuer: directed scenarios plus randomized traffic checked against a
// token-counting reference model; honours ARB_REQ_STARVE_DETECT_EN when defined.
module tb_arb_req_issuer;

    localparam int N     = 10;
    localparam int MAXP  = 15;
    localparam int LIMIT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] push_valid;
    logic [N-1:0] push_ready;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_err;
    logic [N-1:0] starve;

    int n_tests = 0;
    int n_fail  = 0;

    int pend  [N];
    int waitc [N];
    bit err_m;

    arb_req_issuer #(.NUM_REQ(N), .CNT_W(4), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst), .push_valid_i(push_valid), .push_ready_o(push_ready),
        .req_o(req), .gnt_i(gnt), .gnt_err_o(gnt_err), .starve_o(starve)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            waitc[i] = 0;
        end
        err_m = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [N-1:0] e_req, e_rdy, e_stv;
        for (int i = 0; i < N; i++) begin
            e_req[i] = (pend[i] > 0);
            e_rdy[i] = (pend[i] < MAXP);
`ifdef ARB_REQ_STARVE_DETECT_EN
            e_stv[i] = (waitc[i] >= LIMIT);
`else
            e_stv[i] = 1'b0;
`endif
        end
        n_tests++;
        assert (req === e_req) else begin
            n_fail++;
            $error("FAIL %s req got %h exp %h", tag, req, e_req);
        end
        n_tests++;
        assert (push_ready === e_rdy) else begin
            n_fail++;
            $error("FAIL %s push_ready got %h exp %h", tag, push_ready, e_rdy);
        end
        n_tests++;
        assert (gnt_err === err_m) else begin
            n_fail++;
            $error("FAIL %s gnt_err got %b exp %b", tag, gnt_err, err_m);
        end
        n_tests++;
        assert (starve === e_stv) else begin
            n_fail++;
            $error("FAIL %s starve got %h exp %h", tag, starve, e_stv);
        end
    endtask

    // Apply inputs for one clock, advance the model by the token-counting rules, then check.
    task automatic cycle(input logic [N-1:0] pv, input logic [N-1:0] g, input string tag);
        int  np [N];
        int  nw [N];
        bit  ne;
        push_valid = pv;
        gnt        = g;
        ne = ($countones(g) > 1);
        for (int i = 0; i < N; i++) begin
            np[i] = pend[i];
            if (pv[i] && pend[i] < MAXP) np[i] = np[i] + 1;
            if (g[i] && pend[i] > 0)     np[i] = np[i] - 1;
            if (g[i] && pend[i] == 0)    ne = 1'b1;
            if (pend[i] > 0 && !g[i]) nw[i] = (waitc[i] < LIMIT) ? waitc[i] + 1 : LIMIT;
            else                      nw[i] = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            pend[i]  = np[i];
            waitc[i] = nw[i];
        end
        err_m = ne;
        check(tag);
    endtask

    initial begin
        logic [N-1:0] pv, g;
        int r, lane;
        rst = 1'b1;
        push_valid = '0;
        gnt = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset");
        rst = 1'b0;

        // Lane 2: three tokens, then three grants.
        for (int k = 0; k < 3; k++) cycle(10'h004, 10'h000, "lane2_push");
        cycle(10'h000, 10'h000, "lane2_hold");
        for (int k = 0; k < 3; k++) cycle(10'h000, 10'h004, "lane2_gnt");
        cycle(10'h000, 10'h000, "lane2_idle");

        // Lane 0: fill to max, grant at max, then simultaneous push+grant at 14.
        for (int k = 0; k < 16; k++) cycle(10'h001, 10'h000, "lane0_fill");
        cycle(10'h000, 10'h001, "lane0_gnt_at_max");
        cycle(10'h001, 10'h001, "lane0_both_at_14");
        cycle(10'h000, 10'h000, "lane0_hold14");

        // Protocol errors: grant to idle lane 3, then a double grant on lanes 0/1.
        cycle(10'h002, 10'h000, "lane1_push");
        cycle(10'h000, 10'h008, "err_idle_gnt");
        cycle(10'h000, 10'h000, "err_pulse_end");
        cycle(10'h000, 10'h003, "err_double_gnt");
        cycle(10'h000, 10'h000, "err_double_end");

        // Starvation: lane 4 waits past the limit, then is granted.
        cycle(10'h010, 10'h000, "lane4_push");
        for (int k = 0; k < LIMIT + 3; k++) cycle(10'h000, 10'h000, "lane4_wait");
        cycle(10'h000, 10'h010, "lane4_gnt");
        cycle(10'h000, 10'h000, "lane4_after");

        // Randomized traffic: a fill-biased phase then a drain-biased phase.
        for (int k = 0; k < 600; k++) begin
            r  = $urandom_range(0, 7);
            pv = (k % 200 < 100) ? N'($urandom) : N'($urandom & $urandom & $urandom);
            lane = $urandom_range(0, N - 1);
            g = '0;
            if (r >= 3 && r <= 5) begin
                if (pend[lane] > 0 || r == 5) g[lane] = 1'b1;
            end else if (r == 6) begin
                g[lane] = 1'b1;
            end else if (r == 7 && $urandom_range(0, 3) == 0) begin
                g = N'($urandom & $urandom);
            end
            cycle(pv, g, "random");
        end

        // Asynchronous reset with lanes 1 and 5 holding four tokens each.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) cycle(10'h022, 10'h000, "pre_rst_fill");
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        @(posedge clk);
        #1;
        check("rst_held");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cycle(10'h000, 10'h000, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
